// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART types and constants for the TX arbiter slice.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  // Index width for a requester population; a single requester still needs one bit.
  function automatic int uart_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_rr_arbiter
// Brief    : Combinational round-robin selector, searching upward from ptr.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rr_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]              req,
  input  logic [uart_idx_w(NUM_REQ)-1:0]  ptr,
  output logic [NUM_REQ-1:0]              grant_onehot,
  output logic [uart_idx_w(NUM_REQ)-1:0]  grant_idx,
  output logic                            any
);

  localparam int c_IDW = uart_idx_w(NUM_REQ);

  int w_pos;

  // Walk offsets from farthest to nearest so the nearest valid requester wins.
  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    any          = 1'b0;
    w_pos        = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_pos = int'(ptr) + k;
      if (w_pos >= NUM_REQ) w_pos = w_pos - NUM_REQ;
      if (req[w_pos]) begin
        grant_onehot        = '0;
        grant_onehot[w_pos] = 1'b1;
        grant_idx           = c_IDW'(w_pos);
        any                 = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Round-robin byte arbiter feeding a single 8N1 UART transmitter.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int clock    = 100_000_000,
  parameter int baudrate = 115_200,
  parameter int NUM_REQ  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [8*NUM_REQ-1:0]            req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            tx,
  output logic                            busy,
  output logic [uart_idx_w(NUM_REQ)-1:0]  grant_id,
  output logic                            frame_done
);

  localparam int          CLKS_PER_BIT = clock / baudrate;
  localparam int          c_TMR_W      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int          c_IDW        = uart_idx_w(NUM_REQ);
  localparam logic [2:0]  c_LAST_BIT   = 3'(UART_DATA_BITS - 1);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("uart_tx_arbiter: clock/baudrate must be at least 2");
    end
    if (NUM_REQ < 2) begin : g_bad_num_req
      $error("uart_tx_arbiter: NUM_REQ must be at least 2");
    end
  endgenerate

  uart_tx_state_t            r_state, w_next_state;
  logic [c_TMR_W-1:0]        r_timer;
  logic [2:0]                r_bit_idx;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [c_IDW-1:0]          r_ptr, r_grant_id;
  logic                      r_tx, r_busy, r_frame_done;

  logic [NUM_REQ-1:0]        w_grant_onehot;
  logic [c_IDW-1:0]          w_grant_idx;
  logic                      w_any, w_idle, w_accept, w_tick;
  logic [7:0]                w_sel_byte;

  uart_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req          (req_valid),
    .ptr          (r_ptr),
    .grant_onehot (w_grant_onehot),
    .grant_idx    (w_grant_idx),
    .any          (w_any)
  );

  assign w_idle    = (r_state == IDLE) && !rst;
  assign req_ready = w_idle ? w_grant_onehot : '0;
  assign w_accept  = w_idle && w_any;
  assign w_tick    = (r_timer == c_TMR_W'(CLKS_PER_BIT - 1));

  always_comb begin
    w_sel_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant_onehot[i]) w_sel_byte = req_data[8*i +: 8];
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = START;
      START:   if (w_tick) w_next_state = DATA;
      DATA:    if (w_tick && (r_bit_idx == c_LAST_BIT)) w_next_state = STOP;
      STOP:    if (w_tick) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx         <= UART_IDLE_LEVEL;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_grant_id   <= '0;
      r_ptr        <= '0;
      r_shift      <= '0;
      r_timer      <= '0;
      r_bit_idx    <= '0;
    end else begin
      r_frame_done <= 1'b0;
      // Timer restarts on every bit boundary, including DATA-to-DATA bits.
      if ((w_next_state != r_state) || w_tick) r_timer <= '0;
      else                                     r_timer <= r_timer + 1'b1;

      case (r_state)
        IDLE: if (w_accept) begin
          r_shift    <= w_sel_byte;
          r_grant_id <= w_grant_idx;
          r_ptr      <= (w_grant_idx == c_IDW'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
          r_tx       <= 1'b0;
          r_busy     <= 1'b1;
          r_bit_idx  <= '0;
        end
        START: if (w_tick) begin
          r_tx      <= r_shift[0];
          r_bit_idx <= '0;
        end
        DATA: if (w_tick) begin
          if (r_bit_idx == c_LAST_BIT) begin
            r_tx <= UART_IDLE_LEVEL;
          end else begin
            r_shift   <= r_shift >> 1;
            r_tx      <= r_shift[1];
            r_bit_idx <= r_bit_idx + 1'b1;
          end
        end
        STOP: if (w_tick) begin
          r_busy       <= 1'b0;
          r_frame_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign tx         = r_tx;
  assign busy       = r_busy;
  assign grant_id   = r_grant_id;
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Brief    : Self-checking bench for uart_tx_arbiter with CLKS_PER_BIT = 4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

  localparam int N     = 4;
  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           tx, busy, frame_done;
  logic [1:0]     grant_id;

  logic [7:0]     offer [N];
  int             n_cmp = 0, n_err = 0, cyc = 0;
  int             ref_ptr = 0, acc_idx = 0, acc_cyc = 0, last_acc = 0;
  logic [7:0]     acc_byte;
  int             rdy_cnt [N];
  int             idx;
  logic [N-1:0]   m;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_data[8*g +: 8] = offer[g];
  end

  uart_tx_arbiter #(.clock(400), .baudrate(100), .NUM_REQ(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .tx         (tx),
    .busy       (busy),
    .grant_id   (grant_id),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Round-robin reference: first valid index at or after p, modulo N.
  function automatic int model_pick(input logic [N-1:0] mask, input int p);
    for (int k = 0; k < N; k++) begin
      if (mask[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // Line level c cycles after acceptance for an 8N1 frame of byte b.
  function automatic logic frame_bit(input int c, input logic [7:0] b);
    int k;
    k = (c - 1) / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  task automatic wait_accept(output int got_idx);
    bit got;
    int e;
    got     = 1'b0;
    got_idx = -1;
    for (int k = 0; k < 3 * FRAME && !got; k++) begin
      #1;
      for (int i = 0; i < N; i++) if (req_ready[i]) rdy_cnt[i]++;
      if ((req_valid & req_ready) != '0) begin
        got = 1'b1;
        for (int i = 0; i < N; i++) if (req_ready[i]) got_idx = i;
        e = model_pick(req_valid, ref_ptr);
        chk("ready_onehot", 32'($onehot(req_ready)), 32'd1);
        chk("grant_sel", got_idx, e);
        if (e < 0) e = 0;
        acc_idx  = e;
        acc_byte = offer[e];
        last_acc = acc_cyc;
        acc_cyc  = cyc;
        ref_ptr  = (e + 1) % N;
      end else begin
        tick();
      end
    end
    if (!got) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic serve(input logic [N-1:0] clr, input int abort_at,
                       input logic [N-1:0] wd, input logic [N-1:0] add);
    for (int c = 1; c <= FRAME; c++) begin
      tick();
      if (c == 1) begin
        req_valid        = req_valid & ~clr;
        offer[acc_idx]   = 8'($urandom);
        chk("grant_id", grant_id, acc_idx);
      end
      if (c == 10) req_valid = req_valid & ~wd;
      if (c == 20) req_valid = req_valid | add;
      chk("tx_bit", tx, frame_bit(c, acc_byte));
      chk("busy_frame", busy, 1'b1);
      chk("done_early", frame_done, 1'b0);
      #1;
      chk("ready_in_frame", req_ready, '0);
      if (c == abort_at) begin
        rst = 1'b1;
        #1;
        chk("ready_in_rst", req_ready, '0);
        tick();
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", frame_done, 1'b0);
        chk("rst_grant", grant_id, 0);
        rst     = 1'b0;
        ref_ptr = 0;
        for (int k = 0; k < 3; k++) begin
          tick();
          chk("no_done_after_abort", frame_done, 1'b0);
        end
        return;
      end
    end
    tick();
    chk("end_busy", busy, 1'b0);
    chk("frame_done", frame_done, 1'b1);
    chk("end_tx", tx, 1'b1);
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    #1;
    chk("ready_rst_pulse", req_ready, '0);
    tick();
    rst     = 1'b0;
    ref_ptr = 0;
    chk("pulse_tx", tx, 1'b1);
    chk("pulse_busy", busy, 1'b0);
    chk("pulse_grant", grant_id, 0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      offer[i]   = 8'($urandom);
      rdy_cnt[i] = 0;
    end

    // Reset held with every requester asking.
    rst       = 1'b1;
    req_valid = '1;
    for (int k = 0; k < 3; k++) begin
      tick();
      #1;
      chk("reset_ready", req_ready, '0);
      chk("reset_tx", tx, 1'b1);
      chk("reset_busy", busy, 1'b0);
      chk("reset_done", frame_done, 1'b0);
      chk("reset_grant", grant_id, 0);
    end
    rst       = 1'b0;
    req_valid = '0;
    tick();
    chk("idle_tx", tx, 1'b1);

    // Single 0x55 frame from requester 0.
    offer[0]  = 8'h55;
    req_valid = 4'b0001;
    wait_accept(idx);
    chk("single_idx", idx, 0);
    serve(4'b0001, 0, '0, '0);

    // Saturation: grants rotate 0,1,2,3,0 with back-to-back spacing.
    rst_pulse();
    for (int i = 0; i < N; i++) offer[i] = 8'(16 * i + $urandom_range(0, 15));
    req_valid = '1;
    for (int r = 0; r < 5; r++) begin
      wait_accept(idx);
      chk("sat_order", idx, r % N);
      if (r > 0) chk("sat_spacing", acc_cyc - last_acc, FRAME + 1);
      serve((r == 4) ? 4'b1111 : 4'b0000, 0, '0, '0);
    end

    // Pointer continues past the last served requester.
    req_valid = 4'b0100;
    wait_accept(idx);
    chk("ptr_alone", idx, 2);
    serve(4'b0100, 0, '0, '0);
    for (int i = 0; i < N; i++) rdy_cnt[i] = 0;
    req_valid = 4'b1010;
    wait_accept(idx);
    chk("ptr_first", idx, 3);
    serve(4'b1000, 0, '0, '0);
    wait_accept(idx);
    chk("ptr_second", idx, 1);
    serve(4'b0010, 0, '0, '0);
    chk("ready_once_r3", rdy_cnt[3], 1);
    chk("ready_once_r1", rdy_cnt[1], 1);

    // Reset during data bit 3 abandons the frame and clears the pointer.
    req_valid = 4'b0001;
    wait_accept(idx);
    serve(4'b0001, 2 * CPB + 2 + 2 * CPB, '0, '0);
    req_valid = 4'b0110;
    wait_accept(idx);
    chk("post_rst_grant", idx, 1);
    serve(4'b0110, 0, '0, '0);

    // Withdrawal of a waiting requester.
    rst_pulse();
    for (int i = 0; i < N; i++) rdy_cnt[i] = 0;
    req_valid = 4'b0011;
    wait_accept(idx);
    chk("wd_first", idx, 0);
    serve(4'b0001, 0, 4'b0010, 4'b0100);
    wait_accept(idx);
    chk("wd_next", idx, 2);
    chk("wd_no_ready_r1", rdy_cnt[1], 0);
    serve(4'b0100, 0, '0, '0);

    // Randomised traffic against the round-robin model.
    for (int r = 0; r < 8; r++) begin
      if (req_valid == '0) begin
        m = 4'($urandom_range(1, 15));
        for (int i = 0; i < N; i++) if (m[i]) offer[i] = 8'($urandom);
        req_valid = m;
      end
      wait_accept(idx);
      serve(4'($urandom), 0, '0, '0);
    end

    req_valid = '0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
